seq_bitgen: RTL

//   Serial stimulus source that sits directly upstream of the sequence-detector FSM and drives its din.

---
 rtl/seq_bitgen_pkg.sv | 22 ++
 rtl/seq_bitgen_lfsr.sv | 46 ++++
 rtl/seq_bitgen.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/seq_bitgen_pkg.sv
// Shared definitions for the serial bit generator: FSM encoding, LFSR taps, length clamp.
package seq_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2,
        SEQ_RSVD = 2'd3
    } seq_state_e;

    // x^32 + x^22 + x^2 + x + 1, taps on q[31], q[21], q[1], q[0]
    localparam logic [31:0] SEQ_LFSR_TAPS_32 = 32'h8020_0003;

    function automatic int unsigned seq_clamp_len(input int unsigned len, input int unsigned pat_w);
        if (len == 32'd0 || len > pat_w) begin
            return pat_w;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/seq_bitgen_lfsr.sv
// Fibonacci LFSR shifting toward the MSB; the MSB is the serial output bit.
module seq_lfsr
    import seq_pkg::*;
#(
    parameter int              PAT_W = 32,
    parameter logic [PAT_W-1:0] TAPS = PAT_W'(SEQ_LFSR_TAPS_32)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_ld,
    input  logic [PAT_W-1:0] seed,
    input  logic             en,
    output logic [PAT_W-1:0] q
);

    logic [PAT_W-1:0] q_q;
    logic [PAT_W-1:0] q_d;

    // Next-state: an all-zero seed would lock the register, so it becomes 1.
    always_comb begin
        q_d = q_q;
        if (seed_ld) begin
            if (seed == {PAT_W{1'b0}}) begin
                q_d = {{(PAT_W-1){1'b0}}, 1'b1};
            end else begin
                q_d = seed;
            end
        end else if (en) begin
            q_d = {q_q[PAT_W-2:0], ^(q_q & TAPS)};
        end else begin
            q_d = q_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= {PAT_W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/seq_bitgen.sv
// Serial pattern source: shifts a loaded pattern out MSB-first, one-shot or looping.
// Optional PRBS mode is compiled in when SEQ_BITGEN_LFSR_EN is defined.
module seq_bitgen
    import seq_pkg::*;
#(
    parameter int PAT_W = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [IDX_W:0]   len_in,
    input  logic             loop,
    input  logic             start,
    input  logic             stop,
`ifdef SEQ_BITGEN_LFSR_EN
    input  logic             prbs,
`endif
    output logic             bit_out,
    output logic             bit_valid,
    output logic [IDX_W-1:0] bit_idx,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W:0]   LEN_MAX = (IDX_W+1)'(PAT_W);

    seq_state_e       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [IDX_W:0]   len_q, len_d;
    logic             loop_q, loop_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             bit_q, bit_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [PAT_W-1:0] pat_src_s;
    logic [IDX_W-1:0] idx_inc_s;
    logic             last_s;
    logic             go_s;

    assign pat_src_s = load ? pat_in : pat_q;
    assign idx_inc_s = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
    assign last_s    = (({1'b0, idx_q} + {{IDX_W{1'b0}}, 1'b1}) == len_q);
    assign go_s      = (state_q == SEQ_IDLE) && start && !stop;

`ifdef SEQ_BITGEN_LFSR_EN
    logic             prbs_q, prbs_d;
    logic [PAT_W-1:0] lfsr_q;

    seq_lfsr #(
        .PAT_W (PAT_W),
        .TAPS  (PAT_W'(SEQ_LFSR_TAPS_32))
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .seed_ld (go_s && prbs),
        .seed    (pat_src_s),
        .en      ((state_q == SEQ_RUN) && prbs_q && !stop),
        .q       (lfsr_q)
    );
`endif

    // Next-state and next-output logic; stop outranks wrap and end of pass.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        loop_d  = loop_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SEQ_BITGEN_LFSR_EN
        prbs_d  = prbs_q;
`endif
        case (state_q)
            SEQ_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (load) begin
                    pat_d = pat_in;
                    len_d = (IDX_W+1)'(seq_clamp_len(32'(len_in), PAT_W));
                end else begin
                    pat_d = pat_q;
                end
                if (go_s) begin
                    state_d = SEQ_RUN;
                    loop_d  = loop;
`ifdef SEQ_BITGEN_LFSR_EN
                    prbs_d  = prbs;
`endif
                    // A zero seed becomes 1 in the LFSR, whose MSB is still 0.
                    bit_d   = pat_src_s[PAT_W-1];
                    idx_d   = {IDX_W{1'b0}};
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = SEQ_IDLE;
                end
            end
            SEQ_RUN: begin
                if (stop) begin
                    state_d = SEQ_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
`ifdef SEQ_BITGEN_LFSR_EN
                else if (prbs_q) begin
                    idx_d = (idx_q == IDX_MAX) ? {IDX_W{1'b0}} : idx_inc_s;
                    bit_d = lfsr_q[PAT_W-2];
                end
`endif
                else if (last_s) begin
                    if (loop_q) begin
                        idx_d = {IDX_W{1'b0}};
                        bit_d = pat_q[PAT_W-1];
                    end else begin
                        state_d = SEQ_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    idx_d = idx_inc_s;
                    bit_d = pat_q[IDX_MAX - idx_inc_s];
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = SEQ_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= SEQ_IDLE;
            pat_q   <= {PAT_W{1'b0}};
            len_q   <= LEN_MAX;
            loop_q  <= 1'b0;
            idx_q   <= {IDX_W{1'b0}};
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_BITGEN_LFSR_EN
            prbs_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SEQ_BITGEN_LFSR_EN
            prbs_q  <= prbs_d;
`endif
        end
    end

    assign bit_out   = bit_q;
    assign bit_valid = valid_q;
    assign bit_idx   = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
